// File: rtl/req_arbiter83_pkg.sv
// req_arbiter83_pkg
//   Shared definitions for the req_arbiter83 block: arbiter state encoding,
//   requester count / index width, and the active-low 7-segment patterns
//   (bit order gfedcba) for digits 0..7 plus the blank pattern.
//   Optional feature macro used by the block: ROUND_ROBIN_EN.
package req_arbiter83_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;

  function automatic logic [6:0] seg7(input logic [IDXW-1:0] idx);
    logic [6:0] s;
    case (idx)
      3'd0:    s = SEG_0;
      3'd1:    s = SEG_1;
      3'd2:    s = SEG_2;
      3'd3:    s = SEG_3;
      3'd4:    s = SEG_4;
      3'd5:    s = SEG_5;
      3'd6:    s = SEG_6;
      default: s = SEG_7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/req_arbiter83_if.sv
// req_arbiter83_if
//   Request/grant bundle between requesters (master) and the arbiter (slave).
//   Signals:
//     en        arbitration enable
//     req       request lines, one per requester
//     rls       early release of the current grant
//     grant     one-hot grant
//     gnt_idx   binary index of the (last) winner
//     gnt_valid high while grant is non-zero
//     busy      high in GRANT and COOLDOWN
//     hex0      active-low 7-segment digit of gnt_idx, blank when idle
interface req_arbiter83_if;
  import req_arbiter83_pkg::*;

  logic            en;
  logic [NREQ-1:0] req;
  logic            rls;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            busy;
  logic [6:0]      hex0;

  modport master (
    output en, req, rls,
    input  grant, gnt_idx, gnt_valid, busy, hex0
  );

  modport slave (
    input  en, req, rls,
    output grant, gnt_idx, gnt_valid, busy, hex0
  );
endinterface

// File: rtl/req_arbiter83_grant_timer.sv
// grant_timer
//   Loadable down-counter with a zero flag. Load has priority over
//   decrement; decrement saturates at zero.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (count -> 0)
//     load_i        load load_val_i into the counter
//     load_val_i    value to load
//     dec_i         decrement by one
//     zero_o        count is zero
module grant_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/req_arbiter83.sv
// req_arbiter83
//   Time-sliced arbiter for eight requesters sharing one indicator. A winner
//   holds a registered one-hot grant for HOLD_CYCLES cycles (or less on
//   release, loss of its request, or loss of enable), followed by a single
//   COOLDOWN cycle. The winner index and its 7-segment digit are registered
//   alongside the grant.
//   Optional feature macro: ROUND_ROBIN_EN (round-robin winner selection from
//   a rotating pointer); undefined gives fixed priority, highest index wins.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  req_arbiter83_if.slave (en/req/rls in, grant/index/display out)
module req_arbiter83
  import req_arbiter83_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  req_arbiter83_if.slave bus
);

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [IDXW-1:0] idx_q;
  logic            valid_q;
  logic            busy_q;
  logic [6:0]      hex_q;

  logic [IDXW-1:0] winner;
  logic            can_grant;
  logic            end_grant;
  logic            tmr_zero;
  logic            tmr_load;
  logic            tmr_dec;

`ifdef ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr_q;

  // First asserted request at or after the pointer, wrapping 7 -> 0.
  function automatic logic [IDXW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                  input logic [IDXW-1:0] p);
    logic [IDXW-1:0] w;
    logic [IDXW-1:0] cand;
    logic            found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = p + IDXW'(k);
      if (!found && r[cand]) begin
        w     = cand;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = pick_winner(bus.req, ptr_q);
`else
  // Highest asserted index wins, like a priority 8-to-3 encoder.
  function automatic logic [IDXW-1:0] pick_winner(input logic [NREQ-1:0] r);
    logic [IDXW-1:0] w;
    w = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r[k]) begin
        w = IDXW'(k);
      end
    end
    return w;
  endfunction

  assign winner = pick_winner(bus.req);
`endif

  assign can_grant = bus.en && (|bus.req);
  assign end_grant = tmr_zero || bus.rls || !bus.req[idx_q] || !bus.en;

  // A new slice can start from IDLE or at the end of the one COOLDOWN
  // cycle, which keeps back-to-back grants exactly one idle cycle apart.
  assign tmr_load = (state_q != GRANT) && can_grant;
  assign tmr_dec  = (state_q == GRANT) && !end_grant;

  grant_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (CNT_W'(HOLD_CYCLES - 1)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      hex_q   <= SEG_BLANK;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, COOLDOWN: begin
          if (can_grant) begin
            state_q <= GRANT;
            grant_q <= NREQ'(1) << winner;
            idx_q   <= winner;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            hex_q   <= seg7(winner);
`ifdef ROUND_ROBIN_EN
            ptr_q   <= winner + 1'b1;
`endif
          end else begin
            // idx_q keeps the last winner while idle.
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= SEG_BLANK;
          end
        end
        GRANT: begin
          // Any mix of terminating conditions yields a single COOLDOWN.
          if (end_grant) begin
            state_q <= COOLDOWN;
            grant_q <= '0;
            valid_q <= 1'b0;
            hex_q   <= SEG_BLANK;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          hex_q   <= SEG_BLANK;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.hex0      = hex_q;

endmodule

// File: tb/tb_req_arbiter83.sv
// tb_req_arbiter83
//   Directed bench for req_arbiter83 with HOLD_CYCLES=4. Expected values are
//   hand-computed for both the fixed-priority build and the ROUND_ROBIN_EN
//   build.
module tb_req_arbiter83;

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  req_arbiter83_if bus ();

  req_arbiter83 #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [2:0] d);
    logic [6:0] tbl [0:7];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    return tbl[d];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic v, input logic b);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".idx"},   32'(bus.gnt_idx), 32'(idx));
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".busy"},  32'(bus.busy), 32'(b));
    chk({tag, ".hex0"},  32'(bus.hex0), 32'(v ? exp_seg(idx) : 7'h7F));
    $display("step %-10s grant=%02h idx=%0d valid=%0b busy=%0b hex0=%02h",
             tag, bus.grant, bus.gnt_idx, bus.gnt_valid, bus.busy, bus.hex0);
  endtask

  initial begin
    logic [7:0] ga;
    logic [2:0] ia;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    bus.rls = 1'b0;

    // Reset held two cycles with all requests active.
    tick(); check_all("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); check_all("rst2", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ga = RR ? 8'h01 : 8'h80;
    ia = RR ? 3'd0 : 3'd7;
    tick(); check_all("first", ga, ia, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("first_h", ga, ia, 1'b1, 1'b1);
    end
    tick(); check_all("cool0", 8'h00, ia, 1'b0, 1'b1);
    bus.req = 8'h00;
    tick(); check_all("idle0", 8'h00, ia, 1'b0, 1'b0);
    tick(); check_all("idle1", 8'h00, ia, 1'b0, 1'b0);

    // req=05 held: RR alternates 0/2, fixed priority repeats 2.
    rst = 1'b1; bus.req = 8'h05;
    tick(); check_all("rst3", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ga = RR ? 8'h01 : 8'h04;
    ia = RR ? 3'd0 : 3'd2;
    tick(); check_all("sa", ga, ia, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("sa_h", ga, ia, 1'b1, 1'b1);
    end
    tick(); check_all("sa_cool", 8'h00, ia, 1'b0, 1'b1);
    tick(); check_all("sb", 8'h04, 3'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("sb_h", 8'h04, 3'd2, 1'b1, 1'b1);
    end
    tick(); check_all("sb_cool", 8'h00, 3'd2, 1'b0, 1'b1);
    tick(); check_all("sc", ga, ia, 1'b1, 1'b1);

    // Wrap: winner 6 leaves ptr=7; dropping req[6] ends the slice early.
    rst = 1'b1; bus.req = 8'h40;
    tick(); check_all("rst4", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); check_all("w0", 8'h40, 3'd6, 1'b1, 1'b1);
    bus.req = 8'h81;
    tick(); check_all("wdrop", 8'h00, 3'd6, 1'b0, 1'b1);
    tick(); check_all("w1", 8'h80, 3'd7, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("w1_h", 8'h80, 3'd7, 1'b1, 1'b1);
    end
    tick(); check_all("w1_cool", 8'h00, 3'd7, 1'b0, 1'b1);
    ga = RR ? 8'h01 : 8'h80;
    ia = RR ? 3'd0 : 3'd7;
    tick(); check_all("w2", ga, ia, 1'b1, 1'b1);

    // Early release in the 2nd grant cycle, then enable drop.
    rst = 1'b1; bus.req = 8'h05;
    tick(); check_all("rst5", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ga = RR ? 8'h01 : 8'h04;
    ia = RR ? 3'd0 : 3'd2;
    tick(); check_all("e1", ga, ia, 1'b1, 1'b1);
    tick(); check_all("e2", ga, ia, 1'b1, 1'b1);
    bus.rls = 1'b1;
    tick(); check_all("rel", 8'h00, ia, 1'b0, 1'b1);
    bus.rls = 1'b0;
    tick(); check_all("e3", 8'h04, 3'd2, 1'b1, 1'b1);
    bus.en = 1'b0;
    tick(); check_all("en_drop", 8'h00, 3'd2, 1'b0, 1'b1);
    bus.req = 8'hFF;
    tick(); check_all("en_idle", 8'h00, 3'd2, 1'b0, 1'b0);
    tick(); check_all("en_idle2", 8'h00, 3'd2, 1'b0, 1'b0);

    // Release coinciding with natural expiry gives one cooldown.
    bus.en = 1'b1; bus.req = 8'h01;
    tick(); check_all("s1", 8'h01, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("s1_h", 8'h01, 3'd0, 1'b1, 1'b1);
    end
    bus.rls = 1'b1;
    tick(); check_all("both", 8'h00, 3'd0, 1'b0, 1'b1);
    bus.rls = 1'b0;
    tick(); check_all("s2", 8'h01, 3'd0, 1'b1, 1'b1);
    tick(); check_all("s2_h", 8'h01, 3'd0, 1'b1, 1'b1);

    // Reset in the 3rd grant cycle; arbitration restarts from ptr=0.
    rst = 1'b1; bus.req = 8'h05;
    tick(); check_all("rst6", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ga = RR ? 8'h01 : 8'h04;
    ia = RR ? 3'd0 : 3'd2;
    tick(); check_all("g1", ga, ia, 1'b1, 1'b1);
    tick(); check_all("g2", ga, ia, 1'b1, 1'b1);
    tick(); check_all("g3", ga, ia, 1'b1, 1'b1);
    rst = 1'b1;
    tick(); check_all("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); check_all("restart", ga, ia, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
